hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Hazard and pipeline-control unit for the 5-stage pipeline; produces the stall/flush controls consumed by the stage registers, including the synchronous clear on the Decode→Execute control register.
- Detects load-use and branch-compare hazards, generates forwarding selects, and tracks the multi-cycle multiply/divide unit (MDU) so that HI/LO readers and back-to-back MDU ops stall until the result is ready.

Parameters:
- MUL_OP, 5'b11000, ALUcon code of a multiply; must be nonzero.
- DIV_OP, 5'b11001, ALUcon code of a divide; must be nonzero.
- MFHI_OP, 5'b11010, ALUcon code reading HI.
- MFLO_OP, 5'b11011, ALUcon code reading LO.
- MUL_LAT, 4, multiply latency in cycles; range 1–31.
- DIV_LAT, 16, divide latency in cycles; range 1–31.

Ports:
- CLK in 1 — clock, rising edge.
- CLR in 1 — reset. Synchronous, active-high; one clock, no other reset.
- rsD, rtD in 5 each — source registers of the instruction in D.
- ALUconD in 5 — ALU control of the instruction in D.
- branchD in 1 — D holds a branch.
- pcsrcD in 1 — branch/jump taken in D.
- rsE, rtE in 5 each — source registers in E.
- writeregE in 5 — destination register in E.
- regwrE in 1 — register write in E.
- memregE in 2 — result select in E; 2'b01 = load.
- ALUconE in 5 — ALU control in E.
- writeregM in 5, regwrM in 1, memregM in 2 — destination, write enable and result select in M.
- writeregW in 5, regwrW in 1 — destination and write enable in W.
- stallF, stallD out 1 each — hold PC / IF-ID register.
- flushD out 1 — clear IF-ID.
- flushE out 1 — clear the D→E control and data registers (drives their CLR).
- forwardAD, forwardBD out 1 each — forward the M-stage result to the D-stage branch comparator.
- forwardAE, forwardBE out 2 each — E operand select: 00 regfile, 01 W result, 10 M result.
- mdu_start out 1 — pulse: MDU op accepted from E.
- mdu_busy out 1 — MDU result not yet valid.

Behaviour:
- Register $0 never matches in any hazard or forwarding compare.
- **Forwarding (combinational)**
  - forwardAE = 10 if rsE==writeregM && regwrM. Else 01 if rsE==writeregW && regwrW. Else 00. The M match has priority.
  - forwardBE uses the same rule with rtE.
  - forwardAD = (rsD==writeregM && regwrM). forwardBD uses the same rule with rtD.
- **Load-use stall:** lwstall = memregE==01 && regwrE && (rsD==writeregE || rtD==writeregE).
- **Branch stall:** brstall = branchD && ((regwrE && writeregE∈{rsD,rtD}) || (memregM==01 && writeregM∈{rsD,rtD})).
- **MDU counter**
  - State: 5-bit cnt, reset value 0. mdu_busy = (cnt!=0).
  - IDLE (cnt==0): if ALUconE∈{MUL_OP,DIV_OP}, load cnt with MUL_LAT or DIV_LAT at the next edge. mdu_start = 1 that cycle (combinational).
  - BUSY (cnt!=0): cnt decrements by 1 each edge. Result is valid in the first cycle with cnt==0.
  - An op in E at cycle t gives busy for cycles t+1 .. t+LAT.
  - An MDU op in E while busy cannot occur; it is prevented by mdustall. If it does occur, it is ignored and cnt continues unchanged.
- **MDU stall:** mdustall = mdu_busy && ALUconD∈{MUL_OP,DIV_OP,MFHI_OP,MFLO_OP}.
  - An op in E that is loading cnt also stalls a dependent op in D that same cycle.
  - Therefore: mdustall = (mdu_busy || mdu_start) && ALUconD∈{…}.
- **Stall and flush**
  - stall = lwstall | brstall | mdustall.
  - stallF = stallD = stall.
  - flushE = stall.
  - flushD = pcsrcD && !stallD.
- **Reset**
  - While CLR is high: stallF = stallD = 0, flushD = flushE = 1, all forward selects = 0, mdu_start = 0.
  - cnt is cleared to 0 at the edge; mdu_busy = 0 the next cycle.
  - CLR mid-BUSY aborts the MDU count.
- Only the MDU counter is sequential; all other outputs are combinational from inputs and cnt.

Test Plan:
1. **Load-use.** Load to $5 in E (memregE=01, regwrE=1, writeregE=5), rsD=5 → stallF=stallD=flushE=1 for one cycle. With rsD=0 and writeregE=0 instead → no stall.
2. **Forwarding priority.** rsE=7, writeregM=7, regwrM=1, writeregW=7, regwrW=1 → forwardAE=10. Drop regwrM → forwardAE=01. rtE=0 with writeregM=0 → forwardBE=00.
3. **MUL then MFHI.** MUL_OP in E at cycle 0 → mdu_start=1 at cycle 0, mdu_busy=1 at cycles 1–4.
   - MFHI_OP held in D from cycle 0 → stall=1 at cycles 0–4, released at cycle 5.
4. **Branch hazard.** branchD=1, rsD=3, memregM=01, writeregM=3 → stall=1. Next cycle with no hazard and pcsrcD=1 → flushD=1, stallD=0.
5. **Reset mid-DIV.** DIV_OP starts; assert CLR at busy cycle 6 → outputs forced as specified (flushE=1) during CLR. Cycle after CLR deasserts: mdu_busy=0, MFHI in D does not stall.
6. **Back-to-back MDU.** MUL in E while DIV_OP is in D → DIV stalls for MUL_LAT+1 cycles, then issues. mdu_start pulses exactly twice in total.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- hazard detection and pipeline control for the 5-stage pipeline.
//
// Purpose:
//   Produces the stall and flush controls for the stage registers and the
//   forwarding selects for the E-stage ALU and the D-stage branch comparator.
//   It also tracks the multi-cycle multiply/divide unit (MDU), so that HI/LO
//   readers and back-to-back MDU ops wait until the MDU result is ready.
//
// Ports:
//   CLK, CLR              clock (rising edge); synchronous active-high reset
//   rsD, rtD, ALUconD     sources and ALU control of the instruction in D
//   branchD, pcsrcD       D holds a branch / the branch or jump is taken
//   rsE, rtE, writeregE   sources and destination of the instruction in E
//   regwrE, memregE       register write and result select (01 = load) in E
//   ALUconE               ALU control of the instruction in E
//   writeregM, regwrM,
//   memregM               destination, write enable and result select in M
//   writeregW, regwrW     destination and write enable in W
//   stallF, stallD        hold the PC / the IF-ID register
//   flushD                clear the IF-ID register
//   flushE                clear the D->E control and data registers
//   forwardAD, forwardBD  use the M-stage result at the D-stage comparator
//   forwardAE, forwardBE  E operand select: 00 regfile, 01 W, 10 M
//   mdu_start             an MDU op is accepted from E this cycle
//   mdu_busy              the MDU result is not yet valid
module hazard_ctrl #(
  parameter logic [4:0] MUL_OP  = 5'b11000,
  parameter logic [4:0] DIV_OP  = 5'b11001,
  parameter logic [4:0] MFHI_OP = 5'b11010,
  parameter logic [4:0] MFLO_OP = 5'b11011,
  parameter int         MUL_LAT = 4,
  parameter int         DIV_LAT = 16
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] ALUconD,
  input  logic       branchD,
  input  logic       pcsrcD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeregE,
  input  logic       regwrE,
  input  logic [1:0] memregE,
  input  logic [4:0] ALUconE,
  input  logic [4:0] writeregM,
  input  logic       regwrM,
  input  logic [1:0] memregM,
  input  logic [4:0] writeregW,
  input  logic       regwrW,
  output logic       stallF,
  output logic       stallD,
  output logic       flushD,
  output logic       flushE,
  output logic       forwardAD,
  output logic       forwardBD,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
  output logic       mdu_start,
  output logic       mdu_busy
);

  localparam logic [4:0] MUL_LAT_C = 5'(MUL_LAT);
  localparam logic [4:0] DIV_LAT_C = 5'(DIV_LAT);

  // Register $0 is hard-wired to zero, so it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  // ---------------------------------------------------------------------------
  // MDU counter: zero means idle (result valid), nonzero counts down the
  // remaining cycles of the op in flight.
  // ---------------------------------------------------------------------------
  logic [4:0] cnt_q, cnt_d;
  logic       mdu_op_e;
  logic       start_raw;

  always_comb begin
    mdu_op_e  = (ALUconE == MUL_OP) || (ALUconE == DIV_OP);
    start_raw = (cnt_q == 5'd0) && mdu_op_e;
    cnt_d     = cnt_q;
    if (cnt_q != 5'd0) begin
      // An MDU op showing up in E while busy is ignored; the count runs on.
      cnt_d = cnt_q - 5'd1;
    end else if (mdu_op_e) begin
      cnt_d = (ALUconE == MUL_OP) ? MUL_LAT_C : DIV_LAT_C;
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      cnt_q <= 5'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Hazard detection, stall/flush and forwarding (purely combinational).
  // ---------------------------------------------------------------------------
  logic lwstall, brstall, mdustall, mdu_op_d, stall;

  always_comb begin
    lwstall  = (memregE == 2'b01) && regwrE &&
               (reg_match(rsD, writeregE) || reg_match(rtD, writeregE));

    brstall  = branchD &&
               ((regwrE && (reg_match(rsD, writeregE) || reg_match(rtD, writeregE))) ||
                ((memregM == 2'b01) &&
                 (reg_match(rsD, writeregM) || reg_match(rtD, writeregM))));

    mdu_op_d = (ALUconD == MUL_OP) || (ALUconD == DIV_OP) ||
               (ALUconD == MFHI_OP) || (ALUconD == MFLO_OP);
    // The op loading the counter this cycle already blocks a dependent op in D,
    // one cycle before mdu_busy itself rises.
    mdustall = ((cnt_q != 5'd0) || start_raw) && mdu_op_d;

    stall    = lwstall || brstall || mdustall;
  end

  always_comb begin
    stallF    = stall;
    stallD    = stall;
    flushE    = stall;
    flushD    = pcsrcD && !stall;
    forwardAD = regwrM && reg_match(rsD, writeregM);
    forwardBD = regwrM && reg_match(rtD, writeregM);
    mdu_start = start_raw;

    // M has priority over W: it holds the younger value.
    forwardAE = 2'b00;
    if (regwrM && reg_match(rsE, writeregM)) begin
      forwardAE = 2'b10;
    end else if (regwrW && reg_match(rsE, writeregW)) begin
      forwardAE = 2'b01;
    end

    forwardBE = 2'b00;
    if (regwrM && reg_match(rtE, writeregM)) begin
      forwardBE = 2'b10;
    end else if (regwrW && reg_match(rtE, writeregW)) begin
      forwardBE = 2'b01;
    end

    // While in reset, clear both pipeline registers and release every stall.
    if (CLR) begin
      stallF    = 1'b0;
      stallD    = 1'b0;
      flushD    = 1'b1;
      flushE    = 1'b1;
      forwardAD = 1'b0;
      forwardBD = 1'b0;
      forwardAE = 2'b00;
      forwardBE = 2'b00;
      mdu_start = 1'b0;
    end
  end

  // Busy follows the counter only; it drops the cycle after a reset edge.
  assign mdu_busy = (cnt_q != 5'd0);

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl -- scenario bench for hazard_ctrl. Each task drives its
// stimulus one cycle at a time, pushes the expected output vector onto the
// scoreboard, and pops and compares it at the following falling edge.
// Vector order: {stallF, stallD, flushD, flushE, forwardAD, forwardBD,
//                forwardAE[1:0], forwardBE[1:0], mdu_start, mdu_busy}
module tb_hazard_ctrl;

  localparam logic [4:0] MUL  = 5'b11000;
  localparam logic [4:0] DIV  = 5'b11001;
  localparam logic [4:0] MFHI = 5'b11010;

  logic       CLK = 1'b0;
  logic       CLR;
  logic [4:0] rsD, rtD, ALUconD, rsE, rtE, writeregE, ALUconE, writeregM, writeregW;
  logic       branchD, pcsrcD, regwrE, regwrM, regwrW;
  logic [1:0] memregE, memregM;
  logic       stallF, stallD, flushD, flushE, forwardAD, forwardBD, mdu_start, mdu_busy;
  logic [1:0] forwardAE, forwardBE;

  typedef struct {
    string      name;
    logic [11:0] exp;
  } sb_item_t;

  sb_item_t sb[$];
  sb_item_t it;
  int total = 0;
  int bad   = 0;

  wire [11:0] obs = {stallF, stallD, flushD, flushE, forwardAD, forwardBD,
                     forwardAE, forwardBE, mdu_start, mdu_busy};

  hazard_ctrl dut (
    .CLK(CLK), .CLR(CLR),
    .rsD(rsD), .rtD(rtD), .ALUconD(ALUconD), .branchD(branchD), .pcsrcD(pcsrcD),
    .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .regwrE(regwrE),
    .memregE(memregE), .ALUconE(ALUconE),
    .writeregM(writeregM), .regwrM(regwrM), .memregM(memregM),
    .writeregW(writeregW), .regwrW(regwrW),
    .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .mdu_start(mdu_start), .mdu_busy(mdu_busy)
  );

  always #5 CLK = ~CLK;

  function automatic logic [11:0] ev(input logic sf, input logic sd, input logic fd,
                                     input logic fe, input logic ad, input logic bd,
                                     input logic [1:0] ae, input logic [1:0] be,
                                     input logic st, input logic bz);
    return {sf, sd, fd, fe, ad, bd, ae, be, st, bz};
  endfunction

  task automatic idle_inputs();
    CLR = 1'b0;
    rsD = 5'd0; rtD = 5'd0; ALUconD = 5'd0; branchD = 1'b0; pcsrcD = 1'b0;
    rsE = 5'd0; rtE = 5'd0; writeregE = 5'd0; regwrE = 1'b0; memregE = 2'b00;
    ALUconE = 5'd0;
    writeregM = 5'd0; regwrM = 1'b0; memregM = 2'b00;
    writeregW = 5'd0; regwrW = 1'b0;
  endtask

  // Reset with hazards present: stalls released, flushes asserted, no forwarding.
  task automatic test_reset();
    @(posedge CLK); #1;
    idle_inputs();
    CLR = 1'b1;
    memregE = 2'b01; regwrE = 1'b1; writeregE = 5'd5; rsD = 5'd5;
    rsE = 5'd7; writeregM = 5'd7; regwrM = 1'b1; pcsrcD = 1'b1;
    ALUconE = MUL;
    sb.push_back('{"reset_forced", ev(0,0,1,1,0,0,2'b00,2'b00,0,0)});
    @(negedge CLK);
    it = sb.pop_front(); total++;
    if (obs !== it.exp) begin bad++; $display("FAIL %s got=%b exp=%b", it.name, obs, it.exp); end

    @(posedge CLK); #1;
    idle_inputs();
    sb.push_back('{"reset_release", ev(0,0,0,0,0,0,2'b00,2'b00,0,0)});
    @(negedge CLK);
    it = sb.pop_front(); total++;
    if (obs !== it.exp) begin bad++; $display("FAIL %s got=%b exp=%b", it.name, obs, it.exp); end
  endtask

  task automatic test_load_use();
    for (int c = 0; c < 4; c++) begin
      @(posedge CLK); #1;
      idle_inputs();
      memregE = 2'b01; regwrE = 1'b1;
      case (c)
        0: begin writeregE = 5'd5; rsD = 5'd5; end
        1: begin writeregE = 5'd0; rsD = 5'd0; end
        2: begin writeregE = 5'd5; rtD = 5'd5; end
        default: begin writeregE = 5'd5; rsD = 5'd6; rtD = 5'd4; end
      endcase
      if (c == 0 || c == 2)
        sb.push_back('{$sformatf("load_use c%0d", c), ev(1,1,0,1,0,0,2'b00,2'b00,0,0)});
      else
        sb.push_back('{$sformatf("load_use c%0d", c), ev(0,0,0,0,0,0,2'b00,2'b00,0,0)});
      @(negedge CLK);
      it = sb.pop_front(); total++;
      if (obs !== it.exp) begin bad++; $display("FAIL %s got=%b exp=%b", it.name, obs, it.exp); end
    end
  endtask

  task automatic test_forwarding();
    for (int c = 0; c < 5; c++) begin
      @(posedge CLK); #1;
      idle_inputs();
      case (c)
        0: begin rsE = 7; writeregM = 7; regwrM = 1; writeregW = 7; regwrW = 1; end
        1: begin rsE = 7; writeregM = 7; regwrM = 0; writeregW = 7; regwrW = 1; end
        2: begin rtE = 0; writeregM = 0; regwrM = 1; writeregW = 0; regwrW = 1; end
        3: begin rtE = 9; writeregM = 8; regwrM = 1; writeregW = 9; regwrW = 1; end
        default: begin rsD = 7; rtD = 7; writeregM = 7; regwrM = 1; end
      endcase
      case (c)
        0: sb.push_back('{"fwd_m_priority", ev(0,0,0,0,0,0,2'b10,2'b00,0,0)});
        1: sb.push_back('{"fwd_w_only",     ev(0,0,0,0,0,0,2'b01,2'b00,0,0)});
        2: sb.push_back('{"fwd_zero_reg",   ev(0,0,0,0,0,0,2'b00,2'b00,0,0)});
        3: sb.push_back('{"fwd_b_from_w",   ev(0,0,0,0,0,0,2'b00,2'b01,0,0)});
        default: sb.push_back('{"fwd_branch_d", ev(0,0,0,0,1,1,2'b00,2'b00,0,0)});
      endcase
      @(negedge CLK);
      it = sb.pop_front(); total++;
      if (obs !== it.exp) begin bad++; $display("FAIL %s got=%b exp=%b", it.name, obs, it.exp); end
    end
  endtask

  task automatic test_branch();
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK); #1;
      idle_inputs();
      branchD = 1'b1;
      case (c)
        // Load in M feeding the comparator; taken branch must not flush while stalled.
        0: begin rsD = 3; memregM = 2'b01; writeregM = 3; regwrM = 1; pcsrcD = 1; end
        1: begin rtD = 4; regwrE = 1; writeregE = 4; end
        default: begin rsD = 3; rtD = 4; pcsrcD = 1; end
      endcase
      case (c)
        0: sb.push_back('{"branch_load_m", ev(1,1,0,1,1,0,2'b00,2'b00,0,0)});
        1: sb.push_back('{"branch_alu_e",  ev(1,1,0,1,0,0,2'b00,2'b00,0,0)});
        default: sb.push_back('{"branch_taken", ev(0,0,1,0,0,0,2'b00,2'b00,0,0)});
      endcase
      @(negedge CLK);
      it = sb.pop_front(); total++;
      if (obs !== it.exp) begin bad++; $display("FAIL %s got=%b exp=%b", it.name, obs, it.exp); end
    end
  endtask

  // MUL in E at cycle 0; MFHI held in D stalls through cycle 4.
  task automatic test_mul_mfhi();
    logic s, b;
    for (int c = 0; c <= 5; c++) begin
      @(posedge CLK); #1;
      idle_inputs();
      ALUconE = (c == 0) ? MUL : 5'd0;
      ALUconD = MFHI;
      s = (c <= 4);
      b = (c >= 1) && (c <= 4);
      sb.push_back('{$sformatf("mul_mfhi c%0d", c), ev(s,s,0,s,0,0,2'b00,2'b00,c == 0,b)});
      @(negedge CLK);
      it = sb.pop_front(); total++;
      if (obs !== it.exp) begin bad++; $display("FAIL %s got=%b exp=%b", it.name, obs, it.exp); end
    end
  endtask

  // DIV starts at cycle 0, CLR at cycle 6 aborts it.
  task automatic test_reset_mid_div();
    for (int c = 0; c <= 7; c++) begin
      @(posedge CLK); #1;
      idle_inputs();
      if (c == 0) ALUconE = DIV;
      if (c >= 6) ALUconD = MFHI;
      if (c == 6) CLR = 1'b1;
      if (c == 0)
        sb.push_back('{"div_start", ev(0,0,0,0,0,0,2'b00,2'b00,1,0)});
      else if (c <= 5)
        sb.push_back('{$sformatf("div_busy c%0d", c), ev(0,0,0,0,0,0,2'b00,2'b00,0,1)});
      else if (c == 6)
        sb.push_back('{"div_clr", ev(0,0,1,1,0,0,2'b00,2'b00,0,1)});
      else
        sb.push_back('{"div_after_clr", ev(0,0,0,0,0,0,2'b00,2'b00,0,0)});
      @(negedge CLK);
      it = sb.pop_front(); total++;
      if (obs !== it.exp) begin bad++; $display("FAIL %s got=%b exp=%b", it.name, obs, it.exp); end
    end
  endtask

  // MUL in E with DIV waiting in D: DIV stalls MUL_LAT+1 cycles, issues at
  // cycle 6 and is busy through cycle 22.
  task automatic test_back_to_back();
    int starts = 0;
    logic s, b;
    for (int c = 0; c <= 23; c++) begin
      @(posedge CLK); #1;
      idle_inputs();
      if (c == 0) ALUconE = MUL;
      if (c == 6) ALUconE = DIV;
      if (c <= 5) ALUconD = DIV;
      s = (c <= 4);
      b = ((c >= 1) && (c <= 4)) || ((c >= 7) && (c <= 22));
      sb.push_back('{$sformatf("b2b c%0d", c),
                     ev(s,s,0,s,0,0,2'b00,2'b00,(c == 0) || (c == 6),b)});
      @(negedge CLK);
      if (mdu_start === 1'b1) starts++;
      it = sb.pop_front(); total++;
      if (obs !== it.exp) begin bad++; $display("FAIL %s got=%b exp=%b", it.name, obs, it.exp); end
    end
    total++;
    if (starts !== 2) begin
      bad++;
      $display("FAIL b2b_start_count got=%0d exp=2", starts);
    end
  endtask

  initial begin
    idle_inputs();
    CLR = 1'b1;
    test_reset();
    test_load_use();
    test_forwarding();
    test_branch();
    test_mul_mfhi();
    test_reset_mid_div();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
